// File: rtl/pingpong_framebuf_if.sv
// Bus bundle for the ping-pong frame buffer: producer write port, scan read port,
// swap/clear handshakes and status.
interface pingpong_framebuf_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12
) ();
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              swap_req;
    logic              swap_ack;
    logic              clear_req;
    logic              busy;
    logic              front_sel;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req, clear_req,
        input  rd_data, rd_valid, swap_ack, busy, front_sel
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req, clear_req,
        output rd_data, rd_valid, swap_ack, busy, front_sel
    );
endinterface

// File: rtl/pingpong_framebuf.sv
// Double-buffered frame memory: producer writes the back bank, scan reads the front
// bank, a one-cycle swap exchanges them and a clear engine zero-fills the back bank.
module pingpong_framebuf #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic clk,
    input  logic reset_n,
    pingpong_framebuf_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, SWAP} state_t;

    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic              swap_pend_reg, swap_pend_next;
    logic [ADDR_W:0]   clr_cnt_reg, clr_cnt_next;
    logic              front_sel_reg, front_sel_next;
    logic              rd_valid_reg;
    logic              rd_sel_reg;
    logic              rd_any_reg;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              back_sel;

    assign back_sel = ~front_sel_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            swap_pend_reg <= 1'b0;
            clr_cnt_reg   <= '0;
            front_sel_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            swap_pend_reg <= swap_pend_next;
            clr_cnt_reg   <= clr_cnt_next;
            front_sel_reg <= front_sel_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        swap_pend_next = swap_pend_reg;
        clr_cnt_next   = clr_cnt_reg;
        front_sel_next = front_sel_reg;
        case (state_reg)
            IDLE: begin
                // A simultaneous swap request is parked so it runs right after the clear.
                if (bus.clear_req) begin
                    state_next     = CLEAR;
                    clr_cnt_next   = '0;
                    swap_pend_next = swap_pend_reg | bus.swap_req;
                end else if (bus.swap_req || swap_pend_reg) begin
                    state_next = SWAP;
                end
            end
            CLEAR: begin
                clr_cnt_next   = clr_cnt_reg + 1'b1;
                swap_pend_next = swap_pend_reg | bus.swap_req;
                if (clr_cnt_reg == CLR_LAST) begin
                    clr_cnt_next = '0;
                    state_next   = (swap_pend_reg || bus.swap_req) ? SWAP : IDLE;
                end
            end
            SWAP: begin
                front_sel_next = ~front_sel_reg;
                swap_pend_next = 1'b0;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The clear engine takes the back-bank write port outright; producer writes are dropped.
    always_comb begin
        if (state_reg == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_cnt_reg[ADDR_W-1:0];
            mem_data = '0;
        end else begin
            mem_we   = bus.wr_en;
            mem_addr = bus.wr_addr;
            mem_data = bus.wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] q;

            always_ff @(posedge clk) begin
                if (mem_we && (back_sel == 1'(gi)))
                    mem[mem_addr] <= mem_data;
                if (bus.rd_en)
                    q <= mem[bus.rd_addr];
            end
        end
    endgenerate

    // rd_any_reg masks the unreset bank registers so rd_data reads 0 until the first read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_reg <= 1'b0;
            rd_sel_reg   <= 1'b0;
            rd_any_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en) begin
                rd_sel_reg <= front_sel_reg;
                rd_any_reg <= 1'b1;
            end
        end
    end

    assign bus.rd_data   = !rd_any_reg ? '0 : (rd_sel_reg ? g_bank[1].q : g_bank[0].q);
    assign bus.rd_valid  = rd_valid_reg;
    assign bus.swap_ack  = (state_reg == SWAP);
    assign bus.busy      = (state_reg == CLEAR);
    assign bus.front_sel = front_sel_reg;
endmodule

// File: doc/pingpong_framebuf.md
# pingpong_framebuf

Parametrised double-buffered (ping-pong) frame memory on a single clock. The producer side (SPI frame loader) writes into the back bank while the display scan side reads the front bank. A one-cycle swap handshake exchanges the banks between frames. A hardware clear engine zero-fills the back bank without the producer having to stream a blank frame.

## Interface
Parameters:
- DATA_W, 4, bits per pixel word
- ADDR_W, 12, address width per bank
- DEPTH, 1<<ADDR_W, words per bank; must equal 2**ADDR_W

Ports:
- clk  in  1  single system clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe to back bank
- wr_addr  in  ADDR_W  back-bank write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read strobe from front bank
- rd_addr  in  ADDR_W  front-bank read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  high the cycle rd_data holds the result of a read
- swap_req  in  1  request a front/back exchange; single-cycle pulse, level tolerated
- swap_ack  out  1  one-cycle pulse on the cycle the swap takes effect
- clear_req  in  1  request a zero-fill of the back bank
- busy  out  1  high while the clear engine owns the back bank
- front_sel  out  1  index of the current front bank (0 = bank A)

## Operation
- Storage is two arrays, A and B, each DEPTH x DATA_W. The back bank is always the bank selected by ~front_sel.
- Arrays have no reset; their contents after reset are undefined.
- FSM states:
  - IDLE: service writes. If clear_req is sampled, go to CLEAR. Otherwise, if swap_req or swap_pend is sampled, go to SWAP.
  - CLEAR: each cycle write 0 to back[clr_cnt] and increment clr_cnt. After the write at clr_cnt = DEPTH-1, go to SWAP if swap_pend is set, else go to IDLE.
  - SWAP: a single cycle. Toggle front_sel, pulse swap_ack, clear swap_pend, return to IDLE.
- clear_req and swap_req sampled together in IDLE: the clear runs first, then the swap runs immediately after it.
- swap_req during CLEAR sets swap_pend. Multiple requests merge into one swap.
- clear_req during CLEAR or SWAP is ignored; it is not queued.
- wr_en while busy = 1 is dropped. The clear engine has priority and never merges with producer writes.
- wr_en in the SWAP-state cycle writes to the bank that is back during that cycle, i.e. the bank becoming front.
- Reads are accepted in every state. The bank is chosen by the front_sel value at the cycle rd_en is sampled.
- clr_cnt is ADDR_W+1 bits wide. Wrap-around of wr_addr or rd_addr is impossible because all addresses are full-range.

## Timing
- Reset values (asynchronous on reset_n low):
  - rd_data = 0, rd_valid = 0, swap_ack = 0, busy = 0, front_sel = 0
  - state = IDLE, swap_pend = 0, clr_cnt = 0
- Read latency is 1 cycle. With rd_en at edge t, rd_data and rd_valid = 1 appear after edge t+1. rd_data holds its value when rd_en = 0. rd_valid is 0 when the previous cycle had no read.
- Writes take effect at the sampling edge. A read of the same address in the same cycle is impossible because the banks differ.
- Swap from IDLE: swap_req sampled at edge t, state SWAP during cycle t..t+1, swap_ack high for exactly that cycle. front_sel toggles at edge t+1.
- Clear: clear_req sampled at edge t, busy high for exactly DEPTH cycles starting after edge t. A queued swap_ack follows in the next cycle.
- Reset asserted mid-clear aborts the clear immediately. Memory stays partially cleared, and outputs go to their reset values.

## Test plan
- ADDR_W=4: write back[i]=i for i=0..15, swap_req pulse -> swap_ack one cycle later, front_sel=1. Reading addr 5 gives rd_data=5 with rd_valid one cycle after rd_en.
- clear_req, then swap_req 3 cycles later -> busy high exactly 16 cycles, then one swap_ack. Reads of all 16 new-front addresses return 0.
- wr_en addr 2 data 4'hF during busy -> dropped. After the clear and a swap, read addr 2 returns 0.
- clear_req and swap_req in the same cycle -> 16 busy cycles, then swap_ack in the next cycle. Only one swap occurs.
- rd_en in the SWAP cycle -> data comes from the old front bank. rd_en in the following cycle -> data comes from the new front bank.
- Pull reset_n low at clear cycle 7 -> busy=0, front_sel=0, rd_valid=0 asynchronously. After release, a swap_req completes normally.
